pwm_multi_controller: RTL

Multi-channel PWM generator that succeeds the single-channel 8-bit free-running PWM controller. It shares one prescaled period counter across CHANNELS outputs. The counter supports a programmable period and edge- or center-aligned counting. Duty and period values are double-buffered so they change only at a period boundary, and the block drives motor/launcher actuators directly from the system clock domain.

---
 rtl/pwm_multi_controller.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/pwm_multi_controller.sv
// pwm_multi_controller
//   Multi-channel PWM generator. One prescaled period counter (edge- or
//   center-aligned) is shared by CHANNELS compare lanes. Duty, period and
//   mode are double-buffered and only take effect at a period boundary.
// Ports:
//   clk, reset_n            system clock, async active-low reset
//   enable                  run when high; idle (and continuously reload) when low
//   prescale                counter ticks every prescale+1 clocks (live)
//   period, center_mode     shadowed period / alignment, applied at boundary
//   duty_wr/sel/data        duty shadow write port (sel >= CHANNELS ignored)
//   pwm_out                 registered outputs, one clock behind counter_out
//   counter_out             current period counter
//   period_start            one-clock pulse when counter_out shows 0 of a new period

// Per-channel duty shadow/active registers and registered compare.
module pwm_lane #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             wr,
    input  logic             load,
    input  logic [WIDTH-1:0] data,
    input  logic [WIDTH-1:0] counter,
    output logic             pwm
);
    logic [WIDTH-1:0] shadow;
    logic [WIDTH-1:0] active;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shadow <= '0;
            active <= '0;
            pwm    <= 1'b0;
        end else begin
            if (wr)   shadow <= data;
            // load sees the pre-write shadow, so a write landing on a
            // boundary waits one more period.
            if (load) active <= shadow;
            pwm <= enable && (active > counter);
        end
    end
endmodule

module pwm_multi_controller #(
    parameter int CHANNELS   = 4,
    parameter int WIDTH      = 8,
    parameter int PRESCALE_W = 8,
    parameter int SEL_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  enable,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic [WIDTH-1:0]      period,
    input  logic                  center_mode,
    input  logic                  duty_wr,
    input  logic [SEL_W-1:0]      duty_sel,
    input  logic [WIDTH-1:0]      duty_data,
    output logic [CHANNELS-1:0]   pwm_out,
    output logic [WIDTH-1:0]      counter_out,
    output logic                  period_start
);
    localparam logic [0:0] DIR_UP = 1'b0;
    localparam logic [0:0] DIR_DN = 1'b1;

    logic [PRESCALE_W-1:0] pre_cnt;
    logic [WIDTH-1:0]      counter;
    logic [0:0]            dir;
    logic [WIDTH-1:0]      period_act;
    logic                  mode_act;

    logic                  tick;
    logic                  boundary;
    logic [WIDTH-1:0]      next_cnt;
    logic [0:0]            next_dir;

    // Equality (not >=) so a lowered prescale wraps through 2^PRESCALE_W.
    assign tick = enable && (pre_cnt == prescale);

    always_comb begin
        next_cnt = counter;
        next_dir = dir;
        if (period_act == '0) begin
            next_cnt = '0;
        end else if (!mode_act) begin
            next_cnt = (counter >= period_act) ? '0 : counter + 1'b1;
        end else if (dir == DIR_UP) begin
            if (counter >= period_act) begin
                // Peak is shown for one tick only, then fold back down.
                next_cnt = period_act - 1'b1;
                next_dir = DIR_DN;
            end else begin
                next_cnt = counter + 1'b1;
            end
        end else begin
            next_cnt = (counter == '0) ? '0 : counter - 1'b1;
        end
    end

    // Every tick that lands the counter on 0 closes a period, in all modes.
    assign boundary = tick && (next_cnt == '0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pre_cnt      <= '0;
            counter      <= '0;
            dir          <= DIR_UP;
            period_start <= 1'b0;
            period_act   <= '1;
            mode_act     <= 1'b0;
        end else if (!enable) begin
            pre_cnt      <= '0;
            counter      <= '0;
            dir          <= DIR_UP;
            period_start <= 1'b0;
            period_act   <= period;
            mode_act     <= center_mode;
        end else begin
            pre_cnt      <= tick ? '0 : pre_cnt + 1'b1;
            period_start <= boundary;
            if (tick) begin
                counter <= next_cnt;
                dir     <= boundary ? DIR_UP : next_dir;
            end
            if (boundary) begin
                period_act <= period;
                mode_act   <= center_mode;
            end
        end
    end

    assign counter_out = counter;

    genvar i;
    generate
        for (i = 0; i < CHANNELS; i++) begin : g_lane
            pwm_lane #(.WIDTH(WIDTH)) u_lane (
                .clk     (clk),
                .reset_n (reset_n),
                .enable  (enable),
                .wr      (duty_wr && (duty_sel == SEL_W'(i))),
                .load    (boundary || !enable),
                .data    (duty_data),
                .counter (counter),
                .pwm     (pwm_out[i])
            );
        end
    endgenerate
endmodule
